// File: rtl/alu_share_arbiter_if.sv
// Request/response channel bundle between the two ALU requesters and
// alu_share_arbiter. Each field is packed per requester n as
// [n*WIDTH +: WIDTH].
//   req_valid_i  : request valid, one bit per requester
//   req_ready_o  : request granted this cycle
//   req_op_i     : ALU opcode per requester
//   req_a_i      : operand A per requester
//   req_b_i      : operand B per requester
//   rsp_valid_o  : registered result available
//   rsp_ready_i  : requester consumes its result this cycle
//   rsp_result_o : registered result per requester
// Modports: master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int unsigned ALU_OP_WIDTH = 4,
  parameter int unsigned WORD_WIDTH   = 32
);
  logic [1:0]                req_valid_i;
  logic [1:0]                req_ready_o;
  logic [2*ALU_OP_WIDTH-1:0] req_op_i;
  logic [2*WORD_WIDTH-1:0]   req_a_i;
  logic [2*WORD_WIDTH-1:0]   req_b_i;
  logic [1:0]                rsp_valid_o;
  logic [1:0]                rsp_ready_i;
  logic [2*WORD_WIDTH-1:0]   rsp_result_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0)
// and the branch/address unit (requester 1). Round-robin arbitration,
// one grant per cycle, results captured into a per-requester response
// register that holds until consumed.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   bus              : request/response channels (slave side)
//   alu_op_o         : opcode to the shared ALU (ALU_PASS when idle)
//   alu_operand_a_o  : operand A to the ALU (0 when idle)
//   alu_operand_b_o  : operand B to the ALU (0 when idle)
//   alu_result_i     : combinational ALU result
//   conflict_cnt_o   : saturating count of cycles with a valid but
//                      ungranted request
module alu_share_arbiter #(
  parameter int unsigned             ALU_OP_WIDTH = 4,
  parameter int unsigned             WORD_WIDTH   = 32,
  parameter int unsigned             CNT_WIDTH    = 16,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_PASS     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  alu_share_arbiter_if.slave      bus,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [WORD_WIDTH-1:0]   alu_operand_a_o,
  output logic [WORD_WIDTH-1:0]   alu_operand_b_o,
  input  logic [WORD_WIDTH-1:0]   alu_result_i,
  output logic [CNT_WIDTH-1:0]    conflict_cnt_o
);

  logic                  rr_ptr;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic                  conflict;
  logic [1:0]            rsp_valid_q;
  logic [2*WORD_WIDTH-1:0] rsp_result_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // A slot that is draining this cycle can accept a new result, giving
  // one op per cycle per requester. No grant is issued during reset.
  always_comb begin
    elig = bus.req_valid_i & (~rsp_valid_q | bus.rsp_ready_i) & {2{~rst_i}};
    if (elig == 2'b11) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
  end

  assign conflict = |(bus.req_valid_i & ~grant);

  always_comb begin
    alu_op_o        = ALU_PASS;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    if (grant[0]) begin
      alu_op_o        = bus.req_op_i[0 +: ALU_OP_WIDTH];
      alu_operand_a_o = bus.req_a_i[0 +: WORD_WIDTH];
      alu_operand_b_o = bus.req_b_i[0 +: WORD_WIDTH];
    end else if (grant[1]) begin
      alu_op_o        = bus.req_op_i[ALU_OP_WIDTH +: ALU_OP_WIDTH];
      alu_operand_a_o = bus.req_a_i[WORD_WIDTH +: WORD_WIDTH];
      alu_operand_b_o = bus.req_b_i[WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= 1'b0;
    end else if (grant[0]) begin
      rr_ptr <= 1'b1;
    end else if (grant[1]) begin
      rr_ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
    end else begin
      for (int unsigned n = 0; n < 2; n++) begin
        if (grant[n]) begin
          rsp_valid_q[n]                           <= 1'b1;
          rsp_result_q[n*WORD_WIDTH +: WORD_WIDTH] <= alu_result_i;
        end else if (bus.rsp_ready_i[n]) begin
          rsp_valid_q[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (conflict && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.req_ready_o  = grant;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_result_o = rsp_result_q;
  assign conflict_cnt_o   = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, rsp_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;

  logic [3:0]  alu_op0, alu_op4;
  logic [31:0] alu_a0, alu_b0, alu_res0, alu_a4, alu_b4, alu_res4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  int          m_rr;
  logic [1:0]  m_vld;
  logic [31:0] m_res [2];
  int unsigned m_cnt, m_cnt4;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a;
    endcase
  endfunction

  alu_share_arbiter_if #(.ALU_OP_WIDTH(4), .WORD_WIDTH(32)) bus0 ();
  alu_share_arbiter_if #(.ALU_OP_WIDTH(4), .WORD_WIDTH(32)) bus4 ();

  assign bus0.req_valid_i = req_valid;
  assign bus0.rsp_ready_i = rsp_ready;
  assign bus0.req_op_i    = req_op;
  assign bus0.req_a_i     = req_a;
  assign bus0.req_b_i     = req_b;
  assign bus4.req_valid_i = req_valid;
  assign bus4.rsp_ready_i = rsp_ready;
  assign bus4.req_op_i    = req_op;
  assign bus4.req_a_i     = req_a;
  assign bus4.req_b_i     = req_b;

  assign alu_res0 = alu_f(alu_op0, alu_a0, alu_b0);
  assign alu_res4 = alu_f(alu_op4, alu_a4, alu_b4);

  alu_share_arbiter #(.ALU_OP_WIDTH(4), .WORD_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus0.slave),
    .alu_op_o(alu_op0), .alu_operand_a_o(alu_a0), .alu_operand_b_o(alu_b0),
    .alu_result_i(alu_res0), .conflict_cnt_o(cnt16)
  );

  alu_share_arbiter #(.ALU_OP_WIDTH(4), .WORD_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4.slave),
    .alu_op_o(alu_op4), .alu_operand_a_o(alu_a4), .alu_operand_b_o(alu_b4),
    .alu_result_i(alu_res4), .conflict_cnt_o(cnt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_vld = 2'b00; m_res[0] = '0; m_res[1] = '0; m_cnt = 0; m_cnt4 = 0;
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic drive_cycle(input logic [1:0] v, input logic [1:0] r,
                             input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                             input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                             output logic [1:0] got_ready);
    bit e0, e1;
    int g;
    logic [1:0]  exp_ready;
    logic [3:0]  exp_op;
    logic [31:0] exp_a, exp_b;
    req_valid = v; rsp_ready = r;
    req_op = {o1, o0}; req_a = {a1, a0}; req_b = {b1, b0};
    e0 = v[0] && (!m_vld[0] || r[0]);
    e1 = v[1] && (!m_vld[1] || r[1]);
    if (e0 && e1) g = m_rr;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    else          g = -1;
    exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    exp_op = (g < 0) ? OP_PASS : ((g == 0) ? o0 : o1);
    exp_a  = (g < 0) ? 32'd0 : ((g == 0) ? a0 : a1);
    exp_b  = (g < 0) ? 32'd0 : ((g == 0) ? b0 : b1);
    #2;
    got_ready = bus0.req_ready_o;
    chk("req_ready", {62'd0, got_ready}, {62'd0, exp_ready});
    chk("alu_op", {60'd0, alu_op0}, {60'd0, exp_op});
    chk("alu_a", {32'd0, alu_a0}, {32'd0, exp_a});
    chk("alu_b", {32'd0, alu_b0}, {32'd0, exp_b});
    @(posedge clk); #1;
    for (int n = 0; n < 2; n++)
      if (n != g && r[n]) m_vld[n] = 1'b0;
    if (g >= 0) begin
      m_vld[g] = 1'b1;
      m_res[g] = alu_f(exp_op, exp_a, exp_b);
      m_rr = 1 - g;
    end
    if ((v & ~exp_ready) != 2'b00) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    chk("rsp_valid", {62'd0, bus0.rsp_valid_o}, {62'd0, m_vld});
    chk("rsp_result", bus0.rsp_result_o, {m_res[1], m_res[0]});
    chk("conflict_cnt", {48'd0, cnt16}, 64'(m_cnt));
    chk("conflict_cnt4", {60'd0, cnt4}, 64'(m_cnt4));
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  valid, rdy;
    logic [3:0]  op0; logic [31:0] a0, b0;
    logic [3:0]  op1; logic [31:0] a1, b1;
    logic [1:0]  exp_ready, exp_vld;
    logic [31:0] exp_r0, exp_r1;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [1:0]  got;
    logic [1:0]  pv;
    logic [3:0]  po [2];
    logic [31:0] pa [2], pb [2];
    bit          pend [2];
    int          g0, g1;

    tbl[0] = '{2'b11, 2'b00, OP_SUB, 32'd10, 32'd3,   OP_XOR, 32'hF0, 32'hFF, 2'b01, 2'b01, 32'd7,   32'h0,  16'd1};
    tbl[1] = '{2'b10, 2'b00, OP_SUB, 32'd10, 32'd3,   OP_XOR, 32'hF0, 32'hFF, 2'b10, 2'b11, 32'd7,   32'h0F, 16'd1};
    tbl[2] = '{2'b00, 2'b11, OP_ADD, 32'd0,  32'd0,   OP_ADD, 32'd0,  32'd0,  2'b00, 2'b00, 32'd7,   32'h0F, 16'd1};
    tbl[3] = '{2'b01, 2'b00, OP_ADD, 32'd5,  32'd7,   OP_ADD, 32'd0,  32'd0,  2'b01, 2'b01, 32'd12,  32'h0F, 16'd1};
    tbl[4] = '{2'b10, 2'b00, OP_ADD, 32'd5,  32'd7,   OP_ADD, 32'd1,  32'd1,  2'b10, 2'b11, 32'd12,  32'd2,  16'd1};
    tbl[5] = '{2'b11, 2'b10, OP_ADD, 32'd100, 32'd200, OP_SUB, 32'd50, 32'd8, 2'b10, 2'b11, 32'd12,  32'd42, 16'd2};
    tbl[6] = '{2'b11, 2'b01, OP_ADD, 32'd100, 32'd200, OP_SUB, 32'd50, 32'd8, 2'b01, 2'b11, 32'd300, 32'd42, 16'd3};
    tbl[7] = '{2'b00, 2'b11, OP_ADD, 32'd0,  32'd0,   OP_ADD, 32'd0,  32'd0,  2'b00, 2'b00, 32'd300, 32'd42, 16'd3};

    do_reset();
    chk("reset_rsp_valid", {62'd0, bus0.rsp_valid_o}, 64'd0);
    chk("reset_rsp_result", bus0.rsp_result_o, 64'd0);
    chk("reset_cnt", {48'd0, cnt16}, 64'd0);

    // Directed table: arbitration, drain, backpressure and replace-on-drain
    for (int i = 0; i < 8; i++) begin
      drive_cycle(tbl[i].valid, tbl[i].rdy, tbl[i].op0, tbl[i].a0, tbl[i].b0,
                  tbl[i].op1, tbl[i].a1, tbl[i].b1, got);
      chk($sformatf("tbl%0d_ready", i), {62'd0, got}, {62'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_vld", i), {62'd0, bus0.rsp_valid_o}, {62'd0, tbl[i].exp_vld});
      chk($sformatf("tbl%0d_r0", i), {32'd0, bus0.rsp_result_o[31:0]}, {32'd0, tbl[i].exp_r0});
      chk($sformatf("tbl%0d_r1", i), {32'd0, bus0.rsp_result_o[63:32]}, {32'd0, tbl[i].exp_r1});
      chk($sformatf("tbl%0d_cnt", i), {48'd0, cnt16}, {48'd0, tbl[i].exp_cnt});
    end

    // Continuous contention: alternating grants, then counter saturation
    do_reset();
    g0 = 0; g1 = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(2'b11, 2'b11, OP_ADD, 32'(i), 32'd1, OP_ADD, 32'(i), 32'd2, got);
      chk("stream_grant", {62'd0, got}, (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i < 8) begin
        if (got[0]) g0++;
        if (got[1]) g1++;
      end
      if (i == 7) begin
        chk("stream_cnt8", {48'd0, cnt16}, 64'd8);
        chk("stream_g0", 64'(g0), 64'd4);
        chk("stream_g1", 64'(g1), 64'd4);
      end
    end
    chk("sat_cnt4", {60'd0, cnt4}, 64'd15);
    chk("sat_cnt16", {48'd0, cnt16}, 64'd20);

    // Asynchronous reset between edges with both slots full
    do_reset();
    drive_cycle(2'b11, 2'b00, OP_ADD, 32'd1, 32'd2, OP_ADD, 32'd3, 32'd4, got);
    drive_cycle(2'b10, 2'b00, OP_ADD, 32'd1, 32'd2, OP_ADD, 32'd3, 32'd4, got);
    chk("pre_areset_vld", {62'd0, bus0.rsp_valid_o}, 64'd3);
    req_valid = 2'b11;
    #2 rst = 1'b1;
    #1;
    chk("areset_vld", {62'd0, bus0.rsp_valid_o}, 64'd0);
    chk("areset_result", bus0.rsp_result_o, 64'd0);
    chk("areset_cnt", {48'd0, cnt16}, 64'd0);
    chk("areset_ready", {62'd0, bus0.req_ready_o}, 64'd0);
    model_reset();
    req_valid = 2'b00;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    drive_cycle(2'b11, 2'b00, OP_ADD, 32'd1, 32'd2, OP_ADD, 32'd3, 32'd4, got);
    chk("post_areset_grant", {62'd0, got}, 64'd1);

    // Randomized traffic against the reference model
    do_reset();
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n]) begin
          pv[n] = ($urandom_range(0, 3) != 0);
          po[n] = 4'($urandom_range(0, 5));
          pa[n] = $urandom;
          pb[n] = $urandom;
        end
      end
      drive_cycle(pv, 2'($urandom_range(0, 3)), po[0], pa[0], pb[0], po[1], pa[1], pb[1], got);
      for (int n = 0; n < 2; n++) pend[n] = pv[n] && !got[n];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
